// File: rtl/md_seq_unit.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO pair (shift-add multiply, restoring divide).
// Define MD_FAST_MULT_EN to complete MULT/MULTU in one cycle from a combinational product.
module md_seq_unit #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
    logic [63:0]   acc_q, acc_d;
    logic [31:0]   opb_q, opb_d;
    logic [31:0]   araw_q, araw_d;
    logic          is_div_q, is_div_d;
    logic          neg_q, neg_d;
    logic          rneg_q, rneg_d;
    logic          dz_q, dz_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          done_q, done_d;
    logic          div_zero_q, div_zero_d;

    logic          accept;
    logic          is_signed;
    logic          a_neg, b_neg;
    logic [31:0]   a_mag, b_mag;
    logic [32:0]   madd;
    logic [63:0]   mul_next;
    logic [32:0]   rem_sh;
    logic          qbit;
    logic [31:0]   rem_new;
    logic [63:0]   div_next;
    logic [63:0]   prod_signed;
    logic [31:0]   res_hi, res_lo;

    assign accept    = (state_q == IDLE) && start && !flush;
    assign is_signed = ~op[0];
    assign a_neg     = is_signed & a[31];
    assign b_neg     = is_signed & b[31];
    assign a_mag     = a_neg ? (~a + 32'd1) : a;
    assign b_mag     = b_neg ? (~b + 32'd1) : b;

    // Shift-add step: conditionally add multiplicand to the upper half, then shift right with carry.
    assign madd     = acc_q[0] ? ({1'b0, acc_q[63:32]} + {1'b0, opb_q}) : {1'b0, acc_q[63:32]};
    assign mul_next = {madd, acc_q[31:1]};

    // Restoring step: a successful subtract always fits in 32 bits, so the low word of the difference is exact.
    assign rem_sh   = {acc_q[63:32], acc_q[31]};
    assign qbit     = (rem_sh >= {1'b0, opb_q});
    assign rem_new  = qbit ? (rem_sh[31:0] - opb_q) : rem_sh[31:0];
    assign div_next = {rem_new, acc_q[30:0], qbit};

    always_comb begin
        prod_signed = neg_q ? (~acc_q + 64'd1) : acc_q;
        res_hi      = prod_signed[63:32];
        res_lo      = prod_signed[31:0];
        if (is_div_q) begin
            if (dz_q) begin
                res_lo = 32'hFFFF_FFFF;
                res_hi = araw_q;
            end else begin
                res_lo = neg_q  ? (~acc_q[31:0]  + 32'd1) : acc_q[31:0];
                res_hi = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        araw_d     = araw_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rneg_d     = rneg_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;

        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    is_div_d = op[1];
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    dz_d     = op[1] && (b == 32'd0);
                    araw_d   = a;
                    cnt_d    = '0;
                    state_d  = RUN;
                    if (op[1]) begin
                        opb_d = b_mag;
                        acc_d = {32'd0, a_mag};
                    end else begin
                        opb_d = a_mag;
                        acc_d = {32'd0, b_mag};
`ifdef MD_FAST_MULT_EN
                        acc_d   = {32'd0, a_mag} * {32'd0, b_mag};
                        state_d = FIN;
`endif
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(ITER - 1)) begin
                        state_d = FIN;
                        cnt_d   = '0;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                if (!flush) begin
                    hi_d       = res_hi;
                    lo_d       = res_lo;
                    done_d     = 1'b1;
                    div_zero_d = is_div_q & dz_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            araw_q     <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            araw_q     <= araw_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rneg_q     <= rneg_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    // stall is combinational on start so the issuing instruction holds in EX from its first cycle.
    assign stall    = accept || (state_q == RUN);
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_md_seq_unit.sv
// Scoreboard bench for md_seq_unit: directed mul/div vectors, flush, MT writes and async reset.
module tb_md_seq_unit;

    localparam int ITER = 32;
    localparam int DL   = ITER + 2;
`ifdef MD_FAST_MULT_EN
    localparam int ML   = 2;
`else
    localparam int ML   = ITER + 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        flush;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        stall, busy, done, div_zero;
    logic [31:0] hi, lo;

    md_seq_unit #(.ITER(ITER)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .stall(stall), .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic [31:0] lat;
        logic [31:0] id;
        logic [31:0] st;
    } exp_t;

    exp_t sb[$];
    int   ncmp = 0;
    int   nerr = 0;
    int   cyc = 0;
    int   stall_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (stall) stall_cnt <= stall_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        ncmp++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    // Monitor: every done pulse pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                ncmp++;
                nerr++;
                $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, expected no completion", hi, lo);
            end else begin
                e = sb.pop_front();
                $display("vec %0d: hi=%h lo=%h div_zero=%b latency=%0d", e.id, hi, lo, div_zero, cyc - int'(e.st));
                chk($sformatf("v%0d_hi", e.id), hi, e.hi);
                chk($sformatf("v%0d_lo", e.id), lo, e.lo);
                chk($sformatf("v%0d_div_zero", e.id), {31'd0, div_zero}, {31'd0, e.dz});
                chk($sformatf("v%0d_latency", e.id), 32'(cyc - int'(e.st)), e.lat);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic push, input logic [31:0] eh, input logic [31:0] el,
                         input logic edz, input int lat, input int id);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        #1;
        chk($sformatf("v%0d_stall_on_start", id), {31'd0, stall}, 32'd1);
        if (push) sb.push_back('{hi: eh, lo: el, dz: edz, lat: 32'(lat), id: 32'(id), st: 32'(cyc)});
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int id);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (busy) chk($sformatf("v%0d_idle_timeout", id), {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected completion within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int n;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        #2;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_flags", {28'd0, busy, stall, done, div_zero}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        s0 = stall_cnt;
        issue(2'b01, 32'hFFFF_FFFF, 32'h2, 1'b1, 32'h1, 32'hFFFF_FFFE, 1'b0, ML, 1);
        wait_idle(1);
        chk("v1_stall_cycles", 32'(stall_cnt - s0), 32'(ML - 1));

        issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, ML, 2);
        wait_idle(2);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DL, 3);
        wait_idle(3);
        issue(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'hFFFF_FFFD, 1'b0, DL, 4);
        wait_idle(4);
        issue(2'b11, 32'd7, 32'd2, 1'b1, 32'd1, 32'd3, 1'b0, DL, 5);
        wait_idle(5);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, DL, 6);
        wait_idle(6);
        issue(2'b10, 32'h1234, 32'd0, 1'b1, 32'h1234, 32'hFFFF_FFFF, 1'b1, DL, 7);
        wait_idle(7);
        chk("v7_div_zero_level", {31'd0, div_zero}, 32'd1);
        issue(2'b01, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6, 1'b0, ML, 8);
        wait_idle(8);
        tick();

        // Flush on RUN cycle 10 of DIVU 100/7.
        issue(2'b11, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0, 0, 9);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("v9_flush_busy", {31'd0, busy}, 32'd0);
        chk("v9_flush_hi", hi, 32'd0);
        chk("v9_flush_lo", lo, 32'd6);
        issue(2'b11, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0, DL, 10);
        wait_idle(10);
        tick();

        // Flush in IDLE suppresses start.
        start = 1'b1; flush = 1'b1; op = 2'b11; a = 32'd9; b = 32'd2;
        #1;
        chk("v11_idle_flush_stall", {31'd0, stall}, 32'd0);
        tick();
        start = 1'b0; flush = 1'b0;
        chk("v11_idle_flush_busy", {31'd0, busy}, 32'd0);
        chk("v11_idle_flush_lo", lo, 32'd14);

        hi_we = 1'b1; wdata = 32'h1111_2222;
        tick();
        hi_we = 1'b0;
        chk("v12_mthi_hi", hi, 32'h1111_2222);
        chk("v12_mthi_lo", lo, 32'd14);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h3333_4444;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        chk("v13_mt_both_hi", hi, 32'h3333_4444);
        chk("v13_mt_both_lo", lo, 32'h3333_4444);

        // MT write colliding with FIN: FIN result wins.
        issue(2'b01, 32'd4, 32'd5, 1'b1, 32'd0, 32'd20, 1'b0, ML, 14);
        n = 0;
        while (!(busy && !stall) && n < 100) begin
            tick();
            n++;
        end
        if (!(busy && !stall)) chk("v14_fin_timeout", {31'd0, busy && !stall}, 32'd1);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA_5555;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        tick();
        chk("v14_after_hi", hi, 32'd0);
        chk("v14_after_lo", lo, 32'd20);

        issue(2'b10, 32'h55, 32'd0, 1'b1, 32'h55, 32'hFFFF_FFFF, 1'b1, DL, 15);
        wait_idle(15);
        tick();

        // Async reset mid-RUN.
        issue(2'b11, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0, 0, 16);
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("v16_async_hi", hi, 32'd0);
        chk("v16_async_lo", lo, 32'd0);
        chk("v16_async_flags", {28'd0, busy, stall, done, div_zero}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("v16_post_reset_busy", {31'd0, busy}, 32'd0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/md_seq_unit.md
Name: md_seq_unit

Overview:
- Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the MIPS core.
- Accepts MULT/MULTU/DIV/DIVU from the EX stage and runs a 32-iteration shift-add multiply or restoring divide.
- Stalls the pipeline while busy and commits the 64-bit result to HI/LO.
- Services MTHI/MTLO writes and provides HI/LO read-back for MFHI/MFLO.

Parameters:
- ITER, 32, number of iteration cycles per operation; must equal operand width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  EX stage presents a mul/div op this cycle.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  32  rs operand: multiplicand or dividend.
- b  in  32  rt operand: multiplier or divisor.
- flush  in  1  pipeline flush (exception/eret); cancels the in-flight op.
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  32  MTHI/MTLO data.
- stall  out  1  pipeline stall request.
- busy  out  1  sequencer not IDLE.
- done  out  1  one-cycle pulse when HI/LO are updated by a mul/div.
- div_zero  out  1  sticky for one op: last completed divide had b==0.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (async, rst=1): state=IDLE, hi=lo=0, done=0, div_zero=0, busy=0, stall=0, iteration counter=0.
- States:
  - IDLE: on start && !flush, latch operand magnitudes and sign flags, counter=0, go to RUN; else stay.
  - RUN: one iteration per cycle; after ITER iterations (counter==ITER-1) go to FIN.
  - FIN: apply sign correction, write HI/LO, done=1 for this cycle, return to IDLE.
- stall = (IDLE && start && !flush) || RUN. Combinational, so the issuing instruction holds in EX from its first cycle. stall is 0 in FIN, so EX advances in the same cycle HI/LO update.
- Latency: start in cycle N; HI/LO visible from cycle N+ITER+2 (RUN N+1..N+ITER, FIN N+ITER+1, registered outputs next edge).
- Signed handling: operate on |a|, |b| for MULT/DIV; unsigned ops use raw values.
  - MULT: negate the 64-bit product if a[31]^b[31].
  - DIV: quotient sign = a[31]^b[31]; remainder sign = a[31].
  - -2^31 / -1: LO=32'h8000_0000, HI=0 (wraps, no trap).
- Multiply: 64-bit accumulator {hi,lo} = product; shift-add on the multiplier LSB each iteration.
- Divide: restoring; 33-bit partial remainder; LO=quotient, HI=remainder.
- Divide by zero: detected in IDLE; still runs full latency.
  - Result LO=32'hFFFF_FFFF, HI=a (raw dividend).
  - div_zero=1 from FIN until the next FIN. MULT completion clears it.
- flush:
  - In RUN or FIN: return to IDLE next edge, no HI/LO write, done=0.
  - In IDLE: suppresses start. flush has priority over everything except rst.
- start while RUN/FIN: ignored; the pipeline is stalled, so this is a protocol error that must not corrupt state.
- hi_we/lo_we:
  - Write in any state.
  - If FIN commits in the same cycle, the FIN result wins for both registers and the MT write is dropped.
  - hi_we and lo_we together write the same wdata to both.
- hi/lo outputs are the register values, with no forwarding of wdata. The EX forwarding logic handles the one-cycle MT→MF hazard.
- busy = (state != IDLE).

Optional Feature:
- MD_FAST_MULT_EN defined:
  - MULT/MULTU complete in a single cycle: IDLE → FIN using the combinational 64-bit product; stall is asserted only in the start cycle.
  - Latency N+2.
  - DIV/DIVU unchanged.
- Undefined: multiply uses the 32-iteration RUN path described above.

Test Plan:
- MULTU a=32'hFFFF_FFFF, b=32'h2 -> after 34 cycles done=1, hi=32'h1, lo=32'hFFFF_FFFE; stall high for exactly 33 cycles.
- MULT a=-3 (32'hFFFF_FFFD), b=7 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB; with MD_FAST_MULT_EN, same result with done two cycles after start.
- DIV a=-7, b=2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1); DIVU a=7, b=2 -> lo=3, hi=1.
- DIV a=32'h1234, b=0 -> lo=32'hFFFF_FFFF, hi=32'h1234, div_zero=1; a following MULTU 2×3 clears div_zero, lo=6.
- Start DIVU 100/7, assert flush on RUN cycle 10 -> state IDLE next cycle, hi/lo keep prior values, done never pulses; an immediate new DIVU 100/7 gives lo=14, hi=2.
- lo_we=1, wdata=32'hAAAA_5555 in the FIN cycle of MULTU 4×5 -> lo=20, hi=0; rst mid-RUN -> all outputs 0 immediately (async).
